mem_bus_master: RTL and testbench
=================================

# mem_bus_master

Initiator side of the shared 32-bit memory bus. Accepts load/store requests from the core over a valid/ready handshake and drives `Memread`, `Memwrite`, `Addrin` and `BUS` toward the halfword-addressed memory responder. It holds each access stable for a fixed number of cycles, which covers the responder's two-phase fetch and its registered output. On reads it samples `BUS` and returns the data with a one-cycle response pulse.

## Interface
- `HOLD`, 6: cycles the address and command are held per access. Values below 6 are illegal and must be rejected at elaboration.
- `clk` in 1: memory/bus clock, the same clock as the responder.
- `rst_n` in 1: synchronous active-low reset.
- `req_valid` in 1: the core presents a request.
- `req_ready` out 1: the master can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_half` in 1: for stores, 1 = halfword store (low 16 bits), 0 = 32-bit store. Ignored on loads.
- `req_addr` in 14: halfword address. Odd values are legal (unaligned word access).
- `req_wdata` in 32: store data.
- `rsp_valid` out 1: one-cycle completion pulse, for loads and for stores.
- `rsp_rdata` out 32: load data. Valid when `rsp_valid` is high after a load.
- `BUS` inout 32: shared data bus.
- `Memread` out 1: read command to the responder.
- `Memwrite` out 2: write command. 00 = none, 01 = word, 11 = halfword.
- `Addrin` out 14: halfword address to the responder.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - `req_ready`=1; all bus commands deasserted.
  - On `req_valid`&&`req_ready`: latch `req_*` into internal registers, load the counter with HOLD-1, go to ACCESS.
- **ACCESS**
  - `Addrin` = latched address.
  - Load: `Memread`=1, `Memwrite`=00, `BUS` not driven by the master.
  - Store: `Memread`=0, `Memwrite`=01 (word) or 11 (half), `BUS` driven with latched wdata.
  - Counter decrements each cycle. At counter 0, a load captures `BUS` into `rsp_rdata`; the FSM then goes to DONE.
- **DONE**
  - `rsp_valid`=1 for exactly one cycle.
  - `Memread`=0, `Memwrite`=00, `BUS` released. This state is the mandatory turnaround cycle.
  - Next state is IDLE.
- `rsp_rdata` holds its last load value across stores and idle cycles.
- Address arithmetic is the responder's job. The master passes `Addrin` unmodified.
  - A word access at 14'h3FFF wraps its upper half to halfword 0 inside the responder. The master does nothing special for it.
- The master never drives `BUS` while `Memread`=1. `Memread` and a nonzero `Memwrite` are never asserted together.
- `req_valid` arriving while not in IDLE is ignored; it is not queued. The requester must hold `req_valid` until it sees `req_ready`.

## Timing
- Request accepted at edge t.
- ACCESS occupies cycles t+1 … t+HOLD.
- Load data is sampled at the end of cycle t+HOLD.
- `rsp_valid` is high during cycle t+HOLD+1.
- `req_ready` goes high again in cycle t+HOLD+2.
- Throughput: one access per HOLD+2 cycles. That is 8 cycles at the default HOLD.
- Store data and command are stable for all HOLD cycles. The responder may write on any of those cycles; every write uses identical data.
- Reset values: `req_ready`=0 while `rst_n`=0, then 1 in IDLE. `rsp_valid`=0, `rsp_rdata`=0, `Memread`=0, `Memwrite`=00, `Addrin`=0, `BUS`=Z.
- Reset mid-ACCESS: the bus is released at the next edge and no `rsp_valid` is issued. A store interrupted this way may have partially updated memory. This is accepted behaviour.
- Simultaneous `rsp_valid` and a new `req_valid`: the request is not accepted until the following cycle (IDLE).

## Structure
- Shared package `membus_pkg` holds:
  - `Memwrite` encodings: `MW_NONE`=2'b00, `MW_WORD`=2'b01, `MW_HALF`=2'b11.
  - The FSM state enum.
  - `HOLD_MIN`=6.
- The responder uses the same `MW_*` constants.
- Single module. The HOLD counter is inline; no sub-module is warranted.

## Test plan
- Word store 32'hDEADBEEF at 14'h0010, then load 14'h0010 → `rsp_rdata`=32'hDEADBEEF; `rsp_valid` at accept+7 for each access.
- Halfword store 16'h1234 at odd address 14'h0011 after the word store → load 14'h0010 returns 32'h1234BEEF.
- Unaligned load at 14'h0011 over words 32'h11112222 and 32'h33334444 stored at 0x10/0x12 → `rsp_rdata`=32'h44441111.
- Back-to-back load then store with `req_valid` held high → second accept exactly 8 cycles after the first; `Memread` and `Memwrite` never overlap; `BUS` never double-driven (no X on the bus).
- `rst_n` low in the 3rd ACCESS cycle of a store → next edge: `Memwrite`=00, `BUS`=Z, no `rsp_valid`; `req_ready`=1 in the first cycle after `rst_n` rises.
- Load at 14'h3FFF → the master presents 14'h3FFF unchanged; the data returned matches the responder's wrap to halfword 0.

Source files
------------

// File: rtl/mem_bus_master_pkg.sv
// Shared definitions for the memory bus: write-command encodings, master FSM
// states and the minimum legal hold time.
package membus_pkg;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_WORD = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b11;

  localparam int HOLD_MIN = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  function automatic logic [1:0] mw_encode(input logic half);
    mw_encode = half ? MW_HALF : MW_WORD;
  endfunction

endpackage

// File: rtl/mem_bus_master_if.sv
// Core request/response handshake plus the command/address side of the memory
// bus. The shared data lines stay a plain inout on the master.
interface mem_bus_master_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_half;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        Memread;
  logic [1:0]  Memwrite;
  logic [13:0] Addrin;

  modport master (
    input  req_valid, req_we, req_half, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, Memread, Memwrite, Addrin
  );

  modport slave (
    output req_valid, req_we, req_half, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, Memread, Memwrite, Addrin
  );

endinterface

// File: rtl/mem_bus_master.sv
// Initiator for the shared halfword-addressed memory bus: holds each access for
// HOLD cycles, samples read data on the last one, then a turnaround cycle.
module mem_bus_master
  import membus_pkg::*;
#(
  parameter int HOLD = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_master_if.master  mb,
  inout  wire  [31:0]       BUS
);

  localparam int CW = $clog2(HOLD);

  generate
    if (HOLD < HOLD_MIN) begin : g_hold_check
      $error("mem_bus_master: HOLD must be at least %0d", HOLD_MIN);
    end
  endgenerate

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic            we_r;
  logic [13:0]     addr_r;
  logic [31:0]     wdata_r;
  logic            ready_r;
  logic            rsp_valid_r;
  logic [31:0]     rdata_r;
  logic            memread_r;
  logic [1:0]      memwrite_r;
  logic            bus_oe_r;

  assign mb.req_ready = ready_r;
  assign mb.rsp_valid = rsp_valid_r;
  assign mb.rsp_rdata = rdata_r;
  assign mb.Memread   = memread_r;
  assign mb.Memwrite  = memwrite_r;
  assign mb.Addrin    = addr_r;

  // Only stores drive the bus; it is released in DONE so the responder can turn around.
  assign BUS = bus_oe_r ? wdata_r : 32'bz;

  // Single-process FSM with all bus-facing outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      we_r        <= 1'b0;
      addr_r      <= 14'h0000;
      wdata_r     <= 32'h0000_0000;
      ready_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      rdata_r     <= 32'h0000_0000;
      memread_r   <= 1'b0;
      memwrite_r  <= MW_NONE;
      bus_oe_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rsp_valid_r <= 1'b0;
          if (mb.req_valid && ready_r) begin
            ready_r <= 1'b0;
            we_r    <= mb.req_we;
            addr_r  <= mb.req_addr;
            wdata_r <= mb.req_wdata;
            cnt_r   <= CW'(HOLD - 1);
            state_r <= ST_ACCESS;
            if (mb.req_we) begin
              memwrite_r <= mw_encode(mb.req_half);
              bus_oe_r   <= 1'b1;
            end else begin
              memread_r  <= 1'b1;
            end
          end else begin
            ready_r <= 1'b1;
          end
        end

        ST_ACCESS: begin
          if (cnt_r == {CW{1'b0}}) begin
            if (!we_r) begin
              rdata_r <= BUS;
            end
            memread_r   <= 1'b0;
            memwrite_r  <= MW_NONE;
            bus_oe_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end

        ST_DONE: begin
          rsp_valid_r <= 1'b0;
          ready_r     <= 1'b1;
          state_r     <= ST_IDLE;
        end

        default: begin
          rsp_valid_r <= 1'b0;
          memread_r   <= 1'b0;
          memwrite_r  <= MW_NONE;
          bus_oe_r    <= 1'b0;
          ready_r     <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: a halfword memory responder on the bus
// and a flat halfword-array reference model of the expected memory contents.
module tb_mem_bus_master;
  import membus_pkg::*;

  localparam int HOLD = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  wire [31:0] BUS;

  mem_bus_master_if mb();

  mem_bus_master #(.HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mb    (mb),
    .BUS   (BUS)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder: halfword memory, registered read data, word access wraps at 14'h3FFF
  logic [15:0] mem [0:16383];
  logic        mem_clear = 1'b1;
  logic        resp_oe   = 1'b0;
  logic [31:0] resp_q    = 32'h0;
  wire  [13:0] a_hi      = mb.Addrin + 14'd1;

  assign BUS = resp_oe ? resp_q : 32'bz;

  always @(posedge clk) begin
    resp_oe <= mb.Memread;
    resp_q  <= {mem[a_hi], mem[mb.Addrin]};
    if (mem_clear) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 16'h0;
    end else if (mb.Memwrite == MW_WORD) begin
      mem[mb.Addrin] <= BUS[15:0];
      mem[a_hi]      <= BUS[31:16];
    end else if (mb.Memwrite == MW_HALF) begin
      mem[mb.Addrin] <= BUS[15:0];
    end
  end

  int cyc = 0;
  int overlap_cnt = 0;
  int clash_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mb.Memread && mb.Memwrite != MW_NONE) overlap_cnt <= overlap_cnt + 1;
    if (mb.Memread && resp_oe && BUS !== resp_q) clash_cnt <= clash_cnt + 1;
  end

  // Reference model of memory contents
  logic [15:0] ref_mem [0:16383];
  logic [31:0] last_load_exp = 32'h0;

  function automatic logic [31:0] ref_load(input logic [13:0] a);
    logic [13:0] b;
    b = a + 14'd1;
    return {ref_mem[b], ref_mem[a]};
  endfunction

  task automatic ref_store(input logic half, input logic [13:0] a, input logic [31:0] d);
    logic [13:0] b;
    b = a + 14'd1;
    ref_mem[a] = d[15:0];
    if (!half) ref_mem[b] = d[31:16];
  endtask

  logic [13:0] seen_addr;
  logic        seen_rd;
  logic [1:0]  seen_wr;
  logic [31:0] seen_bus;

  task automatic access(input logic we, input logic half, input logic [13:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat);
    int n;
    @(negedge clk);
    mb.req_valid = 1'b1;
    mb.req_we    = we;
    mb.req_half  = half;
    mb.req_addr  = addr;
    mb.req_wdata = wd;
    n = 0;
    while (!mb.req_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    mb.req_valid = 1'b0;
    seen_addr = mb.Addrin;
    seen_rd   = mb.Memread;
    seen_wr   = mb.Memwrite;
    seen_bus  = BUS;
    lat = 1;
    while (!mb.rsp_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    rd = mb.rsp_rdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_clear = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++; if (mb.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b expected 0", mb.req_ready); end
    n_checks++; if (mb.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b expected 0", mb.rsp_valid); end
    n_checks++; if (mb.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h expected 0", mb.rsp_rdata); end
    n_checks++; if (mb.Memread !== 1'b0 || mb.Memwrite !== MW_NONE) begin n_fail++; $display("FAIL reset_cmd got rd=%b wr=%b expected 0/00", mb.Memread, mb.Memwrite); end
    n_checks++; if (mb.Addrin !== 14'h0) begin n_fail++; $display("FAIL reset_addr got %h expected 0", mb.Addrin); end
    mem_clear = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (mb.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b expected 1", mb.req_ready); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    int lat;
    access(1'b1, 1'b0, 14'h0010, 32'hDEADBEEF, rd, lat);
    ref_store(1'b0, 14'h0010, 32'hDEADBEEF);
    n_checks++; if (lat != HOLD + 1) begin n_fail++; $display("FAIL store_latency got %0d expected %0d", lat, HOLD + 1); end
    n_checks++; if (seen_wr !== MW_WORD || seen_rd !== 1'b0) begin n_fail++; $display("FAIL store_cmd got rd=%b wr=%b expected 0/01", seen_rd, seen_wr); end
    n_checks++; if (seen_bus !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_bus got %h expected deadbeef", seen_bus); end
    n_checks++; if (seen_addr !== 14'h0010) begin n_fail++; $display("FAIL store_addr got %h expected 0010", seen_addr); end
    access(1'b0, 1'b0, 14'h0010, 32'h0, rd, lat);
    last_load_exp = ref_load(14'h0010);
    n_checks++; if (lat != HOLD + 1) begin n_fail++; $display("FAIL load_latency got %0d expected %0d", lat, HOLD + 1); end
    n_checks++; if (seen_rd !== 1'b1 || seen_wr !== MW_NONE) begin n_fail++; $display("FAIL load_cmd got rd=%b wr=%b expected 1/00", seen_rd, seen_wr); end
    n_checks++; if (rd !== last_load_exp) begin n_fail++; $display("FAIL load_data got %h expected %h", rd, last_load_exp); end
  endtask

  task automatic test_halfword();
    logic [31:0] rd;
    int lat;
    access(1'b1, 1'b1, 14'h0011, 32'hFFFF1234, rd, lat);
    ref_store(1'b1, 14'h0011, 32'hFFFF1234);
    n_checks++; if (seen_wr !== MW_HALF) begin n_fail++; $display("FAIL half_cmd got %b expected 11", seen_wr); end
    access(1'b0, 1'b0, 14'h0010, 32'h0, rd, lat);
    last_load_exp = ref_load(14'h0010);
    n_checks++; if (rd !== last_load_exp) begin n_fail++; $display("FAIL half_merge got %h expected %h", rd, last_load_exp); end
  endtask

  task automatic test_unaligned();
    logic [31:0] rd;
    int lat;
    access(1'b1, 1'b0, 14'h0010, 32'h11112222, rd, lat);
    ref_store(1'b0, 14'h0010, 32'h11112222);
    access(1'b1, 1'b0, 14'h0012, 32'h33334444, rd, lat);
    ref_store(1'b0, 14'h0012, 32'h33334444);
    access(1'b0, 1'b0, 14'h0011, 32'h0, rd, lat);
    last_load_exp = ref_load(14'h0011);
    n_checks++; if (rd !== last_load_exp) begin n_fail++; $display("FAIL unaligned_load got %h expected %h", rd, last_load_exp); end
  endtask

  task automatic test_back_to_back();
    int t1, t2, n;
    logic [31:0] got;
    got = 32'h0;
    @(negedge clk);
    mb.req_valid = 1'b1;
    mb.req_we    = 1'b0;
    mb.req_half  = 1'b0;
    mb.req_addr  = 14'h0012;
    mb.req_wdata = 32'h0;
    n = 0;
    while (!mb.req_ready && n < 64) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    t1 = cyc;
    mb.req_we    = 1'b1;
    mb.req_addr  = 14'h0014;
    mb.req_wdata = 32'h5A5AA5A5;
    n = 0;
    while (!mb.req_ready && n < 64) begin
      if (mb.rsp_valid) got = mb.rsp_rdata;
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    t2 = cyc;
    mb.req_valid = 1'b0;
    last_load_exp = ref_load(14'h0012);
    n = 0;
    while (!mb.rsp_valid && n < 64) begin @(negedge clk); n++; end
    ref_store(1'b0, 14'h0014, 32'h5A5AA5A5);
    n_checks++; if (t2 - t1 != HOLD + 2) begin n_fail++; $display("FAIL b2b_spacing got %0d expected %0d", t2 - t1, HOLD + 2); end
    n_checks++; if (got !== last_load_exp) begin n_fail++; $display("FAIL b2b_load got %h expected %h", got, last_load_exp); end
    n_checks++; if (mb.rsp_rdata !== last_load_exp) begin n_fail++; $display("FAIL b2b_hold got %h expected %h", mb.rsp_rdata, last_load_exp); end
    n_checks++; if (overlap_cnt != 0) begin n_fail++; $display("FAIL cmd_overlap got %0d expected 0", overlap_cnt); end
    n_checks++; if (clash_cnt != 0) begin n_fail++; $display("FAIL bus_clash got %0d expected 0", clash_cnt); end
  endtask

  task automatic test_reset_mid_access();
    int n;
    @(negedge clk);
    mb.req_valid = 1'b1;
    mb.req_we    = 1'b1;
    mb.req_half  = 1'b0;
    mb.req_addr  = 14'h0040;
    mb.req_wdata = 32'hA5A55A5A;
    n = 0;
    while (!mb.req_ready && n < 64) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    mb.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (mb.Memwrite !== MW_WORD) begin n_fail++; $display("FAIL midrst_pre got %b expected 01", mb.Memwrite); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (mb.Memwrite !== MW_NONE || mb.Memread !== 1'b0) begin n_fail++; $display("FAIL midrst_cmd got rd=%b wr=%b expected 0/00", mb.Memread, mb.Memwrite); end
    n_checks++; if (BUS === 32'hA5A55A5A) begin n_fail++; $display("FAIL midrst_bus got %h expected released", BUS); end
    n_checks++; if (mb.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp got %b expected 0", mb.rsp_valid); end
    n_checks++; if (mb.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata got %h expected 0", mb.rsp_rdata); end
    last_load_exp = 32'h0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (mb.req_ready !== 1'b1 || mb.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_recover got ready=%b rsp=%b expected 1/0", mb.req_ready, mb.rsp_valid); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    int lat;
    access(1'b1, 1'b0, 14'h0000, 32'h5555AAAA, rd, lat);
    ref_store(1'b0, 14'h0000, 32'h5555AAAA);
    access(1'b1, 1'b1, 14'h3FFF, 32'h00007777, rd, lat);
    ref_store(1'b1, 14'h3FFF, 32'h00007777);
    access(1'b0, 1'b0, 14'h3FFF, 32'h0, rd, lat);
    last_load_exp = ref_load(14'h3FFF);
    n_checks++; if (seen_addr !== 14'h3FFF) begin n_fail++; $display("FAIL wrap_addr got %h expected 3fff", seen_addr); end
    n_checks++; if (rd !== last_load_exp) begin n_fail++; $display("FAIL wrap_data got %h expected %h", rd, last_load_exp); end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd;
    logic [13:0] a;
    logic we, half;
    int lat;
    for (int k = 0; k < 24; k++) begin
      we   = 1'($urandom_range(0, 1));
      half = 1'($urandom_range(0, 1));
      a    = 14'h0100 + 14'($urandom_range(0, 255));
      wd   = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      access(we, half, a, wd, rd, lat);
      n_checks++; if (lat != HOLD + 1) begin n_fail++; $display("FAIL rnd_latency[%0d] got %0d expected %0d", k, lat, HOLD + 1); end
      if (we) begin
        ref_store(half, a, wd);
        n_checks++; if (rd !== last_load_exp) begin n_fail++; $display("FAIL rnd_hold[%0d] got %h expected %h", k, rd, last_load_exp); end
      end else begin
        last_load_exp = ref_load(a);
        n_checks++; if (rd !== last_load_exp) begin n_fail++; $display("FAIL rnd_load[%0d] addr %h got %h expected %h", k, a, rd, last_load_exp); end
      end
      @(negedge clk);
      n_checks++; if (mb.rsp_valid !== 1'b0 || mb.req_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_post[%0d] got rsp=%b ready=%b expected 0/1", k, mb.rsp_valid, mb.req_ready); end
    end
    n_checks++; if (overlap_cnt != 0 || clash_cnt != 0) begin n_fail++; $display("FAIL rnd_bus got overlap=%0d clash=%0d expected 0/0", overlap_cnt, clash_cnt); end
  endtask

  initial begin
    mb.req_valid = 1'b0;
    mb.req_we    = 1'b0;
    mb.req_half  = 1'b0;
    mb.req_addr  = 14'h0;
    mb.req_wdata = 32'h0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = 16'h0;
    test_reset();
    test_store_load();
    test_halfword();
    test_unaligned();
    test_back_to_back();
    test_reset_mid_access();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
